// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice.
package imem_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } imem_arb_state_t;

    localparam int IMEM_AW         = 6;
    localparam int IMEM_WORDS      = 64;
    localparam int IMEM_STARVE_MAX = 4;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles a debug request has been denied.
module imem_starve_ctr
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic d_req,
    input  logic d_gnt,
    output logic hit
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (!d_req || d_gnt) begin
            count_next = '0;
        end else if (count_reg != CW'(STARVE_MAX)) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign hit = (count_reg == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction memory port between fetch and debug, with a halt handshake.
// Optional debug write path enabled by defining IMEM_WRITE_EN.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int N          = 32,
    parameter int AW         = IMEM_AW,
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [N-1:0]  f_data,
    output logic          cpu_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [N-1:0]  d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [N-1:0]  d_rdata,
    input  logic          dbg_halt,
    output logic          halt_ack,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_q,
    output logic          mem_we,
    output logic [N-1:0]  mem_wdata
);

    imem_arb_state_t state_reg;
    imem_arb_state_t state_next;
    logic            starve_hit;
    logic            f_valid_reg;
    logic            d_valid_reg;
    logic [N-1:0]    f_data_reg;
    logic [N-1:0]    d_rdata_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN always lasts one cycle so an in-flight fetch can return before HALTED.
    always_comb begin
        state_next = state_reg;
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        case (state_reg)
            RUN: begin
                d_gnt = d_req && (!f_req || starve_hit);
                f_gnt = f_req && !d_gnt;
                if (dbg_halt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                d_gnt      = d_req;
                state_next = HALTED;
            end
            HALTED: begin
                d_gnt = d_req;
                if (!dbg_halt) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    imem_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .d_req (d_req),
        .d_gnt (d_gnt),
        .hit   (starve_hit)
    );

    assign cpu_stall = f_req && !f_gnt;
    assign halt_ack  = (state_reg == HALTED);
    assign mem_addr  = f_gnt ? f_addr : (d_gnt ? d_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

`ifdef IMEM_WRITE_EN
    assign mem_we = d_gnt && d_we;
`else
    logic unused_d_we;
    assign unused_d_we = d_we;
    assign mem_we      = 1'b0;
`endif

    // mem_q is sampled on the grant edge, so a debug write returns the pre-write word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_valid_reg <= 1'b0;
            d_valid_reg <= 1'b0;
            f_data_reg  <= '0;
            d_rdata_reg <= '0;
        end else begin
            f_valid_reg <= f_gnt;
            d_valid_reg <= d_gnt;
            if (f_gnt) begin
                f_data_reg <= mem_q;
            end
            if (d_gnt) begin
                d_rdata_reg <= mem_q;
            end
        end
    end

    assign f_valid = f_valid_reg;
    assign d_valid = d_valid_reg;
    assign f_data  = f_data_reg;
    assign d_rdata = d_rdata_reg;

endmodule
